dmem_lsu: RTL
=============

Name: dmem_lsu

Overview:
Parametrised successor to the data memory. It is a byte-addressable synchronous RAM behind a valid/ready request/response interface.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Detects misaligned and out-of-window accesses.
- Has a configurable read pipeline latency.
- Keeps the read-only ID word window.

It sits between the core's memory stage and on-chip RAM.

Parameters:
- ADDR_W, 32, request address width.
- DEPTH_WORDS, 1024, RAM depth in 32-bit words; must be a power of 2.
- RAM_BASE, 32'h8000_0000, base byte address of the RAM window.
- ID_BASE, 32'h0010_0000, base byte address of the 3-word read-only ID window.
- RD_LAT, 1, request-to-response latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and returns err.
- req_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  access fault.

Behaviour:
- Reset (rst=0 at a clock edge):
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All in-flight pipeline stages are invalidated.
  - req_ready=0 while rst=0; req_ready=1 in the first cycle after release.
  - RAM contents are not cleared.
- Every accepted request, load or store, produces exactly one response. Responses are in order.
- Latency: a request accepted at edge N gives rsp_valid=1 from edge N+RD_LAT. Back-to-back acceptance gives one response per cycle.
- Pipeline: RD_LAT valid-tagged stages. If rsp_valid && !rsp_ready, the whole pipeline holds, req_ready=0, and rsp_* stay stable. Otherwise req_ready=1.
- Decode:
  - RAM hit when RAM_BASE <= addr < RAM_BASE + 4*DEPTH_WORDS.
  - ID hit when ID_BASE <= addr < ID_BASE + 12.
  - Anything else is an error.
- ID window is read-only. Words 0/1/2 = 32'h11987251, 32'h18790475, 32'h10257233.
- Alignment:
  - Half with addr[0]=1 is an error.
  - Word with addr[1:0]!=0 is an error.
  - Byte is always aligned.
- Error cases: out-of-window, misaligned, size 11, or store to the ID window. In each case rsp_err=1, rsp_rdata=0, and RAM is not modified.
- Stores:
  - Byte-lane enables are generated from size and addr[1:0]: byte gives 4'b0001<<addr[1:0]; half gives 4'b0011<<{addr[1],1'b0}; word gives 4'b1111.
  - wdata is replicated into the selected lanes.
  - The RAM write happens at the acceptance edge.
- Loads: the RAM is read at the acceptance edge. The selected lane is shifted to bit 0, then extended per req_unsigned.
- Read-after-write: a store accepted at edge N followed by a load of the same word accepted at N+1 returns the new data. No forwarding is needed, because the write lands at N.
- Request fields are sampled only at acceptance. req_* are don't-care when req_valid=0.

Decomposition:
- Package dmem_pkg holds:
  - size encodings (SZ_B, SZ_H, SZ_W);
  - the three ID constants and the ID window size;
  - a lane-enable function;
  - a load-extract/extend function.
- Sub-module dmem_bank: single-port synchronous RAM of DEPTH_WORDS x 32 with a 4-bit byte write enable and a registered read port.
- dmem_lsu contains decode, the error check, the RD_LAT stage shift register, and the stall logic.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 throughout; req_ready=1 on the first cycle after release.
- ID reads: word loads at 32'h00100000, 32'h00100004, 32'h00100008 -> rdata 32'h11987251, 32'h18790475, 32'h10257233, err=0. Each arrives RD_LAT cycles after acceptance. Run with RD_LAT=1 and RD_LAT=3.
- Store widths at 32'h80000000:
  - word store 32'h20221118;
  - then byte store 8'hA5 at +1;
  - then half store 16'hBEEF at +2;
  - then word load -> 32'hBEEFA518.
  - Byte load at +1, signed -> 32'hFFFFFFA5; unsigned -> 32'h000000A5.
- Faults, each giving err=1, rdata=0, and RAM unchanged:
  - half at 32'h80000001;
  - word at 32'h80000002;
  - store to 32'h00100000;
  - load at 32'h40000000;
  - size=11.
- Backpressure: issue 6 back-to-back loads with rsp_ready low for 4 cycles mid-stream -> req_ready=0 during the stall, rsp_* held stable, all 6 responses in order with none lost or duplicated.
- Reset mid-operation: assert rst=0 with 2 requests in flight -> no response ever appears for them; a subsequent load of previously written data returns the old value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings, ID window constants and lane helpers for the data memory LSU.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [31:0] ID_WORD0 = 32'h1198_7251;
    localparam logic [31:0] ID_WORD1 = 32'h1879_0475;
    localparam logic [31:0] ID_WORD2 = 32'h1025_7233;
    localparam int unsigned ID_WINDOW_BYTES = 12;

    // Request metadata carried alongside the registered RAM read.
    typedef struct packed {
        logic       valid;
        logic       err;
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [1:0] off;
        logic       is_id;
        logic [1:0] id_idx;
    } meta_t;

    function automatic logic [3:0] lane_enable(logic [1:0] size, logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << {off[1], 1'b0};
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Move the addressed lane down to bit 0 and extend it to 32 bits.
    function automatic logic [31:0] load_extract(logic [31:0] word, logic [1:0] size,
                                                 logic [1:0] off, logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_B:    return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic [31:0] id_word(logic [1:0] idx);
        case (idx)
            2'd0:    return ID_WORD0;
            2'd1:    return ID_WORD1;
            2'd2:    return ID_WORD2;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake bundle between the memory stage and the LSU.
interface dmem_lsu_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bank.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_bank #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic             clk,
    input  logic             en,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    // Write enabled lanes and capture the old word; read data only moves on access.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[idx];
        end
    end
endmodule

// File: rtl/dmem_lsu.sv
// Data memory LSU: decode, fault check, RD_LAT response pipeline with full-stall backpressure.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] RAM_BASE    = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] ID_BASE     = 32'h0010_0000,
    parameter int unsigned       RD_LAT      = 1
) (
    input  logic           clk,
    input  logic           rst,
    dmem_lsu_if.slave      bus
);
    localparam int unsigned       IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] RAM_BYTES = ADDR_W'(4 * DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] ID_BYTES  = ADDR_W'(ID_WINDOW_BYTES);

    logic [ADDR_W-1:0] ram_off;
    logic [ADDR_W-1:0] id_off;
    logic              ram_hit;
    logic              id_hit;
    logic              misaligned;
    logic              req_err;
    logic              advance;
    logic              accept;
    logic [3:0]        bank_be;
    logic [31:0]       bank_wdata;
    logic [31:0]       bank_rdata;
    meta_t             meta_d;
    meta_t             meta_q;
    logic              s0_err;
    logic [31:0]       s0_data;
    logic [RD_LAT-1:0] vld_q;
    logic              err_q  [RD_LAT];
    logic [31:0]       data_q [RD_LAT];

    // Address decode and fault classification of the presented request.
    always_comb begin
        ram_off = bus.req_addr - RAM_BASE;
        id_off  = bus.req_addr - ID_BASE;
        ram_hit = (bus.req_addr >= RAM_BASE) && (ram_off < RAM_BYTES);
        id_hit  = (bus.req_addr >= ID_BASE) && (id_off < ID_BYTES);
        case (bus.req_size)
            SZ_H:    misaligned = bus.req_addr[0];
            SZ_W:    misaligned = (bus.req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        req_err = (bus.req_size == 2'b11) || !(ram_hit || id_hit) || misaligned
                  || (bus.req_we && id_hit && !ram_hit);
    end

    // Handshake, stall and RAM port control; a blocked output freezes every stage.
    always_comb begin
        advance       = !(vld_q[RD_LAT-1] && !bus.rsp_ready);
        bus.req_ready = rst && advance;
        accept        = bus.req_valid && bus.req_ready;
        bank_be       = (accept && bus.req_we && ram_hit && !req_err)
                        ? lane_enable(bus.req_size, bus.req_addr[1:0]) : 4'b0000;
        case (bus.req_size)
            SZ_B:    bank_wdata = {4{bus.req_wdata[7:0]}};
            SZ_H:    bank_wdata = {2{bus.req_wdata[15:0]}};
            default: bank_wdata = bus.req_wdata;
        endcase
        meta_d        = '{valid:  accept,
                          err:    req_err,
                          we:     bus.req_we,
                          size:   bus.req_size,
                          uns:    bus.req_unsigned,
                          off:    bus.req_addr[1:0],
                          is_id:  id_hit && !ram_hit,
                          id_idx: id_off[3:2]};
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk   (clk),
        .en    (accept),
        .be    (bank_be),
        .idx   (ram_off[IDX_W+1:2]),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    // Form the load result once the RAM word (or ID constant) is available.
    always_comb begin
        s0_err = meta_q.err;
        if (meta_q.err || meta_q.we) begin
            s0_data = 32'h0;
        end else if (meta_q.is_id) begin
            s0_data = load_extract(id_word(meta_q.id_idx), meta_q.size, meta_q.off, meta_q.uns);
        end else begin
            s0_data = load_extract(bank_rdata, meta_q.size, meta_q.off, meta_q.uns);
        end
    end

    // Metadata register plus RD_LAT valid-tagged response stages.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= '0;
            vld_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                err_q[i]  <= 1'b0;
                data_q[i] <= 32'h0;
            end
        end else if (advance) begin
            meta_q    <= meta_d;
            vld_q[0]  <= meta_q.valid;
            err_q[0]  <= s0_err;
            data_q[0] <= s0_data;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                err_q[i]  <= err_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    // Response outputs read zero whenever no response is presented.
    always_comb begin
        bus.rsp_valid = vld_q[RD_LAT-1];
        bus.rsp_err   = vld_q[RD_LAT-1] && err_q[RD_LAT-1];
        bus.rsp_rdata = vld_q[RD_LAT-1] ? data_q[RD_LAT-1] : 32'h0;
    end
endmodule
